res_station: RTL
================

RES_STATION -- requirements
Module: res_station

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, meaning the number of station entries (2..8).
REQ-002 SHALL have parameter BASE_TAG, default 5'd8, meaning entry i owns tag BASE_TAG+i.
REQ-003 SHALL have parameter INVALID_TAG, default 5'b11111, meaning the operand-ready marker.
REQ-004 SHALL provide clk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL provide rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL provide in_issue_valid  in  1  issue request.
REQ-007 SHALL provide in_issue_op  in  4  opcode.
REQ-008 SHALL provide in_issue_val_1 / in_issue_val_2  in  32 each  operand values from the register status table.
REQ-009 SHALL provide in_issue_tag_1 / in_issue_tag_2  in  5 each  producer tags; INVALID_TAG = value valid.
REQ-010 SHALL provide out_issue_ready  out  1  at least one free entry (combinational).
REQ-011 SHALL provide out_issue_tag  out  5  tag of the entry the next issue takes (combinational).
REQ-012 SHALL provide in_CDB_broadcast, in_CDB_tag[5], in_CDB_val[32]  in  common data bus.
REQ-013 SHALL provide out_dispatch_valid  out  1, out_dispatch_op  out  4, out_dispatch_val_1/out_dispatch_val_2  out  32, out_dispatch_tag  out  5  to the functional unit.
REQ-014 SHALL provide in_fu_ready  in  1  functional unit accepts dispatch.

Function
REQ-015 SHALL hold per entry: busy, op, V1, Q1, V2, Q2.
REQ-016 SHALL drive out_issue_ready=1 iff any entry is not busy, and out_issue_tag=BASE_TAG+lowest free index (INVALID_TAG when full).
REQ-017 SHALL, on a rising edge with in_issue_valid && out_issue_ready, write the lowest free entry: busy=1, op, V/Q from the inputs; issue while full SHALL be ignored, with no state change.
REQ-018 SHALL, on issue with in_CDB_broadcast=1 and in_issue_tag_x==in_CDB_tag (not INVALID_TAG), capture Vx=in_CDB_val and Qx=INVALID_TAG.
REQ-019 SHALL, on each edge with in_CDB_broadcast=1, for every busy entry with Qx==in_CDB_tag, set Vx=in_CDB_val and Qx=INVALID_TAG; a broadcast of INVALID_TAG SHALL be ignored.
REQ-020 SHALL consider an entry ready when busy && Q1==INVALID_TAG && Q2==INVALID_TAG, evaluated on registered state (pre-edge).
REQ-021 SHALL load the dispatch output registers from the lowest-index ready entry on an edge where (!out_dispatch_valid || in_fu_ready), and free that entry on the same edge.
REQ-022 SHALL set out_dispatch_tag=BASE_TAG+index of the dispatched entry.
REQ-023 SHALL clear out_dispatch_valid on an edge with in_fu_ready=1 and no ready entry.
REQ-024 SHALL hold out_dispatch_* stable while out_dispatch_valid=1 and in_fu_ready=0.
REQ-025 SHALL have minimum latency issue-edge to out_dispatch_valid=1 of one cycle (operands valid at issue: ready after edge N, dispatched at edge N+1).
REQ-026 SHALL make an operand completed by CDB at edge N dispatchable no earlier than edge N+1.
REQ-027 SHALL compute free/ready from pre-edge state, so an entry freed by dispatch is not reusable by an issue on the same edge.
REQ-028 SHALL apply issue, CDB snoop and dispatch on the same edge without interference.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, clear all busy bits, set all Q to INVALID_TAG, and set out_dispatch_valid=0, out_dispatch_op=0, out_dispatch_val_1/2=0, out_dispatch_tag=INVALID_TAG.
REQ-030 SHALL give rst priority over issue, CDB and dispatch, aborting in-flight entries.

Verification
REQ-031 Reset, then issue op=3, val 6/7, tags INVALID, fu_ready=1 -> out_issue_tag=8 at issue; out_dispatch_valid=1 one edge later with val 6/7, tag 8.
REQ-032 Issue with tag_1=5, then CDB tag 5 val 0x2A -> no dispatch before CDB edge; dispatch at next edge with val_1=0x2A.
REQ-033 Issue with tag_2=12 in the same cycle as CDB tag 12 val 9 -> entry captures 9; dispatches one edge later.
REQ-034 Four issues waiting on tag 5, fifth issue -> out_issue_ready=0, out_issue_tag=31, fifth ignored; CDB tag 5 -> dispatches in tag order 8,9,10,11 with fu_ready=1.
REQ-035 fu_ready=0 with two ready entries -> output holds tag 8 stably; fu_ready=1 -> tag 9 next edge, then valid drops.
REQ-036 rst asserted with three busy entries and valid dispatch -> next edge all outputs at reset values, out_issue_tag=8.

Source files
------------

// File: rtl/res_station_if.sv
// Issue, common-data-bus and dispatch signals of the reservation station.
// The station is the slave side; the issue/CDB/FU environment is the master side.
interface res_station_if;
    logic        in_issue_valid;
    logic [3:0]  in_issue_op;
    logic [31:0] in_issue_val_1;
    logic [31:0] in_issue_val_2;
    logic [4:0]  in_issue_tag_1;
    logic [4:0]  in_issue_tag_2;
    logic        out_issue_ready;
    logic [4:0]  out_issue_tag;

    logic        in_CDB_broadcast;
    logic [4:0]  in_CDB_tag;
    logic [31:0] in_CDB_val;

    logic        out_dispatch_valid;
    logic [3:0]  out_dispatch_op;
    logic [31:0] out_dispatch_val_1;
    logic [31:0] out_dispatch_val_2;
    logic [4:0]  out_dispatch_tag;
    logic        in_fu_ready;

    modport slave (
        input  in_issue_valid, in_issue_op, in_issue_val_1, in_issue_val_2,
               in_issue_tag_1, in_issue_tag_2,
               in_CDB_broadcast, in_CDB_tag, in_CDB_val, in_fu_ready,
        output out_issue_ready, out_issue_tag,
               out_dispatch_valid, out_dispatch_op, out_dispatch_val_1,
               out_dispatch_val_2, out_dispatch_tag
    );

    modport master (
        output in_issue_valid, in_issue_op, in_issue_val_1, in_issue_val_2,
               in_issue_tag_1, in_issue_tag_2,
               in_CDB_broadcast, in_CDB_tag, in_CDB_val, in_fu_ready,
        input  out_issue_ready, out_issue_tag,
               out_dispatch_valid, out_dispatch_op, out_dispatch_val_1,
               out_dispatch_val_2, out_dispatch_tag
    );
endinterface

// File: rtl/res_station.sv
// Tomasulo-style reservation station: issue into the lowest free entry, snoop the CDB
// for pending operands, and dispatch the lowest-index ready entry to the functional unit.
module res_station #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter logic [4:0]  BASE_TAG    = 5'd8,
    parameter logic [4:0]  INVALID_TAG = 5'b11111
) (
    input logic          clk,
    input logic          rst,
    res_station_if.slave rs
);
    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic [3:0]  op_q [NUM_ENTRIES];
    logic [3:0]  op_d [NUM_ENTRIES];
    logic [31:0] v1_q [NUM_ENTRIES];
    logic [31:0] v1_d [NUM_ENTRIES];
    logic [31:0] v2_q [NUM_ENTRIES];
    logic [31:0] v2_d [NUM_ENTRIES];
    logic [4:0]  q1_q [NUM_ENTRIES];
    logic [4:0]  q1_d [NUM_ENTRIES];
    logic [4:0]  q2_q [NUM_ENTRIES];
    logic [4:0]  q2_d [NUM_ENTRIES];

    logic        disp_valid_q, disp_valid_d;
    logic [3:0]  disp_op_q, disp_op_d;
    logic [31:0] disp_v1_q, disp_v1_d;
    logic [31:0] disp_v2_q, disp_v2_d;
    logic [4:0]  disp_tag_q, disp_tag_d;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             rdy_found;
    logic [IDX_W-1:0] rdy_idx;
    logic             cdb_live;

    function automatic logic [4:0] tag_of(input logic [IDX_W-1:0] idx);
        return BASE_TAG + 5'(idx);
    endfunction

    assign cdb_live = rs.in_CDB_broadcast && (rs.in_CDB_tag != INVALID_TAG);

    // Free and ready selection look only at registered state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy_q[i] && (q1_q[i] == INVALID_TAG) && (q2_q[i] == INVALID_TAG) && !rdy_found) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    assign rs.out_issue_ready    = free_found;
    assign rs.out_issue_tag      = free_found ? tag_of(free_idx) : INVALID_TAG;
    assign rs.out_dispatch_valid = disp_valid_q;
    assign rs.out_dispatch_op    = disp_op_q;
    assign rs.out_dispatch_val_1 = disp_v1_q;
    assign rs.out_dispatch_val_2 = disp_v2_q;
    assign rs.out_dispatch_tag   = disp_tag_q;

    always_comb begin
        busy_d       = busy_q;
        op_d         = op_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        q1_d         = q1_q;
        q2_d         = q2_q;
        disp_valid_d = disp_valid_q;
        disp_op_d    = disp_op_q;
        disp_v1_d    = disp_v1_q;
        disp_v2_d    = disp_v2_q;
        disp_tag_d   = disp_tag_q;

        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (cdb_live && busy_q[i]) begin
                if (q1_q[i] == rs.in_CDB_tag) begin
                    v1_d[i] = rs.in_CDB_val;
                    q1_d[i] = INVALID_TAG;
                end
                if (q2_q[i] == rs.in_CDB_tag) begin
                    v2_d[i] = rs.in_CDB_val;
                    q2_d[i] = INVALID_TAG;
                end
            end
        end

        if (!disp_valid_q || rs.in_fu_ready) begin
            if (rdy_found) begin
                disp_valid_d     = 1'b1;
                disp_op_d        = op_q[rdy_idx];
                disp_v1_d        = v1_q[rdy_idx];
                disp_v2_d        = v2_q[rdy_idx];
                disp_tag_d       = tag_of(rdy_idx);
                busy_d[rdy_idx]  = 1'b0;
            end else begin
                disp_valid_d = 1'b0;
            end
        end

        // The issued entry was free pre-edge, so it never collides with snoop or dispatch.
        if (rs.in_issue_valid && free_found) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = rs.in_issue_op;
            if (cdb_live && (rs.in_issue_tag_1 == rs.in_CDB_tag)) begin
                v1_d[free_idx] = rs.in_CDB_val;
                q1_d[free_idx] = INVALID_TAG;
            end else begin
                v1_d[free_idx] = rs.in_issue_val_1;
                q1_d[free_idx] = rs.in_issue_tag_1;
            end
            if (cdb_live && (rs.in_issue_tag_2 == rs.in_CDB_tag)) begin
                v2_d[free_idx] = rs.in_CDB_val;
                q2_d[free_idx] = INVALID_TAG;
            end else begin
                v2_d[free_idx] = rs.in_issue_val_2;
                q2_d[free_idx] = rs.in_issue_tag_2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            disp_valid_q <= 1'b0;
            disp_op_q    <= '0;
            disp_v1_q    <= '0;
            disp_v2_q    <= '0;
            disp_tag_q   <= INVALID_TAG;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                op_q[i] <= '0;
                v1_q[i] <= '0;
                v2_q[i] <= '0;
                q1_q[i] <= INVALID_TAG;
                q2_q[i] <= INVALID_TAG;
            end
        end else begin
            busy_q       <= busy_d;
            op_q         <= op_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            q1_q         <= q1_d;
            q2_q         <= q2_d;
            disp_valid_q <= disp_valid_d;
            disp_op_q    <= disp_op_d;
            disp_v1_q    <= disp_v1_d;
            disp_v2_q    <= disp_v2_d;
            disp_tag_q   <= disp_tag_d;
        end
    end
endmodule
